// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 AR/R channel pair between NUM_REQ read
// requesters. AR requests are arbitrated round-robin, with a limit on the
// number of bursts each requester may have in flight. The requester index is
// prepended to the downstream AXI ID, and R beats are routed back by that
// index.
//
// Handshake rule, on every AR and R interface: a transfer happens in a cycle
// where valid and ready are both high. Once valid is raised, the source holds
// valid and its payload stable until that transfer. Ready may depend
// combinationally on valid.
module axi_rd_arbiter #(
    parameter int  NUM_REQ   = 3,
    parameter int  ADDR_W    = 64,
    parameter int  DATA_W    = 64,
    parameter int  ID_W      = 4,
    parameter int  MAX_OUTST = 4,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int MID_W     = ID_W + IDX_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // requester AR channels
    input  logic [NUM_REQ-1:0]        req_ar_valid_i,
    output logic [NUM_REQ-1:0]        req_ar_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_ar_addr_i,
    input  logic [NUM_REQ*ID_W-1:0]   req_ar_id_i,
    input  logic [NUM_REQ*8-1:0]      req_ar_len_i,
    // requester R channels (payload shared)
    output logic [NUM_REQ-1:0]        req_r_valid_o,
    input  logic [NUM_REQ-1:0]        req_r_ready_i,
    output logic [DATA_W-1:0]         req_r_data_o,
    output logic [ID_W-1:0]           req_r_id_o,
    output logic [1:0]                req_r_resp_o,
    output logic                      req_r_last_o,
    // downstream AR channel
    output logic                      m_ar_valid_o,
    input  logic                      m_ar_ready_i,
    output logic [ADDR_W-1:0]         m_ar_addr_o,
    output logic [MID_W-1:0]          m_ar_id_o,
    output logic [7:0]                m_ar_len_o,
    // downstream R channel
    input  logic                      m_r_valid_i,
    output logic                      m_r_ready_o,
    input  logic [DATA_W-1:0]         m_r_data_i,
    input  logic [1:0]                m_r_resp_i,
    input  logic                      m_r_last_i,
    input  logic [MID_W-1:0]          m_r_id_i,
    // status / debug
    output logic                      err_o,
    output logic                      dbg_state_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt;
    logic [ADDR_W-1:0]  hold_addr;
    logic [ID_W-1:0]    hold_id;
    logic [7:0]         hold_len;
    logic [CNT_W-1:0]   cnt [NUM_REQ];

    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W:0]     cand;
    logic               ar_load;
    logic               ar_hs;

    logic [IDX_W-1:0]   r_idx;
    logic               idx_ok;
    logic [CNT_W-1:0]   cnt_sel;
    logic               sel_ready;
    logic               bad_beat;
    logic [NUM_REQ-1:0] inc;
    logic [NUM_REQ-1:0] dec;

    // A requester competes only while its in-flight burst count is below the limit.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_ar_valid_i[i] & (cnt[i] != CNT_W'(MAX_OUTST));
        end
    end

    // Round-robin search: take the first eligible index starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && elig[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    // State register for the AR grant FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: IDLE picks a winner, HOLD presents it until the handshake.
    always_comb begin
        state_nxt = state;
        ar_load   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = HOLD;
                    ar_load   = 1'b1;
                end
            end
            HOLD: begin
                if (m_ar_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ar_hs        = (state == HOLD) & m_ar_ready_i;
    assign m_ar_valid_o = (state == HOLD);
    assign m_ar_addr_o  = hold_addr;
    assign m_ar_id_o    = {gnt, hold_id};
    assign m_ar_len_o   = hold_len;
    assign dbg_state_o  = state;

    // Capture the winner's request so the downstream AR stays stable in HOLD.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt       <= '0;
            hold_addr <= '0;
            hold_id   <= '0;
            hold_len  <= '0;
        end else if (ar_load) begin
            gnt       <= pick;
            hold_addr <= req_ar_addr_i[int'(pick)*ADDR_W +: ADDR_W];
            hold_id   <= req_ar_id_i[int'(pick)*ID_W +: ID_W];
            hold_len  <= req_ar_len_i[int'(pick)*8 +: 8];
        end
    end

    // The next search starts just after the requester that was last served.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (ar_hs) begin
            if (gnt == IDX_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt + 1'b1;
            end
        end
    end

    // The granted requester sees its AR ready in the same cycle as the downstream handshake.
    always_comb begin
        req_ar_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ar_ready_o[i] = ar_hs & (gnt == IDX_W'(i));
        end
    end

    assign r_idx  = m_r_id_i[MID_W-1:ID_W];
    assign idx_ok = ({1'b0, r_idx} < (IDX_W+1)'(NUM_REQ));

    // Select the addressed requester's counter and ready without indexing out of range.
    always_comb begin
        cnt_sel   = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_idx == IDX_W'(i)) begin
                cnt_sel   = cnt[i];
                sel_ready = req_r_ready_i[i];
            end
        end
    end

    // A beat for a nonexistent requester, or a last beat with nothing in flight,
    // is swallowed so the downstream slave can never stall on it.
    assign bad_beat    = m_r_valid_i & (~idx_ok | (m_r_last_i & (cnt_sel == '0)));
    assign m_r_ready_o = bad_beat | (idx_ok & sel_ready);

    assign req_r_data_o = m_r_data_i;
    assign req_r_id_o   = m_r_id_i[ID_W-1:0];
    assign req_r_resp_o = m_r_resp_i;
    assign req_r_last_o = m_r_last_i;

    // Per-beat routing, plus the increment/decrement strobes for each counter.
    always_comb begin
        req_r_valid_o = '0;
        inc           = '0;
        dec           = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_r_valid_o[i] = m_r_valid_i & ~bad_beat & (r_idx == IDX_W'(i));
            dec[i]           = req_r_valid_o[i] & sel_ready & m_r_last_i;
            inc[i]           = req_ar_ready_o[i];
        end
    end

    // Outstanding-burst counters; a simultaneous increment and decrement cancel out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Error pulse for one cycle after a swallowed beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= bad_beat;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter: grant order, outstanding limits,
// R routing and error pulses, with hand-computed expected values.
module tb_axi_rd_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 4;
    localparam int MID_W   = 6;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_ar_valid_i = '0;
    logic [NUM_REQ-1:0]        req_ar_ready_o;
    logic [NUM_REQ*ADDR_W-1:0] req_ar_addr_i = '0;
    logic [NUM_REQ*ID_W-1:0]   req_ar_id_i = '0;
    logic [NUM_REQ*8-1:0]      req_ar_len_i = '0;
    logic [NUM_REQ-1:0]        req_r_valid_o;
    logic [NUM_REQ-1:0]        req_r_ready_i = '0;
    logic [DATA_W-1:0]         req_r_data_o;
    logic [ID_W-1:0]           req_r_id_o;
    logic [1:0]                req_r_resp_o;
    logic                      req_r_last_o;
    logic                      m_ar_valid_o;
    logic                      m_ar_ready_i = 1'b0;
    logic [ADDR_W-1:0]         m_ar_addr_o;
    logic [MID_W-1:0]          m_ar_id_o;
    logic [7:0]                m_ar_len_o;
    logic                      m_r_valid_i = 1'b0;
    logic                      m_r_ready_o;
    logic [DATA_W-1:0]         m_r_data_i = '0;
    logic [1:0]                m_r_resp_i = '0;
    logic                      m_r_last_i = 1'b0;
    logic [MID_W-1:0]          m_r_id_i = '0;
    logic                      err_o;
    logic                      dbg_state_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];

    axi_rd_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_ar_valid_i (req_ar_valid_i),
        .req_ar_ready_o (req_ar_ready_o),
        .req_ar_addr_i  (req_ar_addr_i),
        .req_ar_id_i    (req_ar_id_i),
        .req_ar_len_i   (req_ar_len_i),
        .req_r_valid_o  (req_r_valid_o),
        .req_r_ready_i  (req_r_ready_i),
        .req_r_data_o   (req_r_data_o),
        .req_r_id_o     (req_r_id_o),
        .req_r_resp_o   (req_r_resp_o),
        .req_r_last_o   (req_r_last_o),
        .m_ar_valid_o   (m_ar_valid_o),
        .m_ar_ready_i   (m_ar_ready_i),
        .m_ar_addr_o    (m_ar_addr_o),
        .m_ar_id_o      (m_ar_id_o),
        .m_ar_len_o     (m_ar_len_o),
        .m_r_valid_i    (m_r_valid_i),
        .m_r_ready_o    (m_r_ready_o),
        .m_r_data_i     (m_r_data_i),
        .m_r_resp_i     (m_r_resp_i),
        .m_r_last_i     (m_r_last_i),
        .m_r_id_i       (m_r_id_i),
        .err_o          (err_o),
        .dbg_state_o    (dbg_state_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] addr_of(input int i);
        return 64'h1000_0000 + 64'(i) * 64'h100;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        req_ar_valid_i = '0;
        m_ar_ready_i   = 1'b0;
        m_r_valid_i    = 1'b0;
        m_r_last_i     = 1'b0;
        m_r_id_i       = '0;
        req_r_ready_i  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic r_drive(input logic v, input logic [1:0] idx, input logic [3:0] id,
                           input logic last, input logic [63:0] data, input logic [2:0] rdy);
        m_r_valid_i   = v;
        m_r_id_i      = {idx, id};
        m_r_last_i    = last;
        m_r_data_i    = data;
        m_r_resp_i    = 2'b00;
        req_r_ready_i = rdy;
    endtask

    // Watch the downstream AR for n handshakes; each one is scored against exp_q.
    task automatic run_ar(input int n);
        int         got = 0;
        int         cyc = 0;
        logic [1:0] e;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m_ar_valid_o && m_ar_ready_i) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd3;
                check("ar_gnt_idx",   64'(m_ar_id_o[5:4]), 64'(e));
                check("ar_id_low",    64'(m_ar_id_o[3:0]), 64'(4'h8 + 4'(e)));
                check("ar_len",       64'(m_ar_len_o),     64'(8'(e) + 8'd1));
                check("ar_addr",      m_ar_addr_o,         addr_of(int'(e)));
                check("ar_ready_hot", 64'(req_ar_ready_o), 64'(3'b001 << e));
                got++;
            end
        end
        check("ar_handshake_count", 64'(got), 64'(n));
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ar_addr_i[i*ADDR_W +: ADDR_W] = addr_of(i);
            req_ar_id_i[i*ID_W +: ID_W]       = 4'h8 + 4'(i);
            req_ar_len_i[i*8 +: 8]            = 8'(i + 1);
        end

        // 1. Reset values, then reset asserted while holding an AR.
        repeat (2) @(negedge clk);
        check("rst_ar_valid", 64'(m_ar_valid_o),   64'd0);
        check("rst_ar_ready", 64'(req_ar_ready_o), 64'd0);
        check("rst_err",      64'(err_o),          64'd0);
        check("rst_state",    64'(dbg_state_o),    64'd0);
        rst            = 1'b0;
        req_ar_valid_i = 3'b001;
        repeat (2) @(negedge clk);
        check("hold_ar_valid", 64'(m_ar_valid_o), 64'd1);
        check("hold_state",    64'(dbg_state_o),  64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_ar_valid", 64'(m_ar_valid_o), 64'd0);
        check("async_rst_state",    64'(dbg_state_o),  64'd0);

        // 2. All requesters valid: grant order 0,1,2,0,1,2.
        apply_reset();
        req_ar_valid_i = 3'b111;
        m_ar_ready_i   = 1'b1;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        run_ar(6);

        // 3. Requester 1 fills its limit, others keep going, one R last frees it.
        apply_reset();
        req_ar_valid_i = 3'b010;
        m_ar_ready_i   = 1'b1;
        exp_q = '{2'd1, 2'd1, 2'd1, 2'd1};
        run_ar(4);
        req_ar_valid_i = 3'b111;
        exp_q = '{2'd2, 2'd0, 2'd2, 2'd0};
        run_ar(4);
        req_ar_valid_i = 3'b010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("req1_blocked", 64'(m_ar_valid_o), 64'd0);
        end
        r_drive(1'b1, 2'd1, 4'h3, 1'b1, 64'hA1, 3'b010);
        #1;
        check("r1_valid", 64'(req_r_valid_o), 64'b010);
        check("r1_ready", 64'(m_r_ready_o),   64'd1);
        check("r1_id",    64'(req_r_id_o),    64'h3);
        @(posedge clk);
        #1;
        r_drive(1'b0, 2'd0, 4'h0, 1'b0, 64'h0, 3'b000);
        exp_q = '{2'd1};
        run_ar(1);

        // 4. Burst of 4 beats to requester 2 with its counter full.
        apply_reset();
        req_ar_valid_i = 3'b100;
        m_ar_ready_i   = 1'b1;
        exp_q = '{2'd2, 2'd2, 2'd2, 2'd2};
        run_ar(4);
        r_drive(1'b1, 2'd2, 4'h5, 1'b0, 64'hD0, 3'b000);
        #1;
        check("r2_stall_ready", 64'(m_r_ready_o),   64'd0);
        check("r2_stall_valid", 64'(req_r_valid_o), 64'b100);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("req2_blocked", 64'(m_ar_valid_o), 64'd0);
            r_drive(1'b1, 2'd2, 4'h5, (b == 3), 64'hD0 + 64'(b), 3'b100);
            #1;
            check("r2_valid", 64'(req_r_valid_o), 64'b100);
            check("r2_ready", 64'(m_r_ready_o),   64'd1);
            check("r2_id",    64'(req_r_id_o),    64'h5);
            check("r2_data",  req_r_data_o,       64'hD0 + 64'(b));
            check("r2_last",  64'(req_r_last_o),  64'(b == 3));
        end
        @(posedge clk);
        #1;
        r_drive(1'b0, 2'd0, 4'h0, 1'b0, 64'h0, 3'b000);
        exp_q = '{2'd2};
        run_ar(1);

        // 5. R last for requester 0 in its AR handshake cycle: count stays at 1.
        apply_reset();
        req_ar_valid_i = 3'b001;
        m_ar_ready_i   = 1'b1;
        exp_q = '{2'd0};
        run_ar(1);
        @(negedge clk);
        @(negedge clk);
        check("same_cycle_ar_valid", 64'(m_ar_valid_o), 64'd1);
        r_drive(1'b1, 2'd0, 4'h2, 1'b1, 64'hB0, 3'b001);
        #1;
        check("same_cycle_ar_ready", 64'(req_ar_ready_o), 64'b001);
        check("same_cycle_r_ready",  64'(m_r_ready_o),    64'd1);
        check("same_cycle_r_valid",  64'(req_r_valid_o),  64'b001);
        @(posedge clk);
        #1;
        req_ar_valid_i = 3'b000;
        r_drive(1'b0, 2'd0, 4'h0, 1'b0, 64'h0, 3'b000);
        @(negedge clk);
        r_drive(1'b1, 2'd0, 4'h2, 1'b1, 64'hB1, 3'b001);
        @(posedge clk);
        #1;
        r_drive(1'b0, 2'd0, 4'h0, 1'b0, 64'h0, 3'b000);
        @(negedge clk);
        check("cnt0_one_left_no_err", 64'(err_o), 64'd0);
        r_drive(1'b1, 2'd0, 4'h2, 1'b1, 64'hB2, 3'b000);
        #1;
        check("underflow_r_valid", 64'(req_r_valid_o), 64'd0);
        check("underflow_r_ready", 64'(m_r_ready_o),   64'd1);
        @(posedge clk);
        #1;
        r_drive(1'b0, 2'd0, 4'h0, 1'b0, 64'h0, 3'b000);
        @(negedge clk);
        check("underflow_err", 64'(err_o), 64'd1);
        @(negedge clk);
        check("underflow_err_clear", 64'(err_o), 64'd0);

        // 6. Illegal index 3: beat swallowed, one-cycle error pulse.
        apply_reset();
        @(negedge clk);
        check("idx3_err_before", 64'(err_o), 64'd0);
        r_drive(1'b1, 2'd3, 4'h1, 1'b0, 64'hC0, 3'b000);
        #1;
        check("idx3_r_ready", 64'(m_r_ready_o),   64'd1);
        check("idx3_r_valid", 64'(req_r_valid_o), 64'd0);
        @(posedge clk);
        #1;
        r_drive(1'b0, 2'd0, 4'h0, 1'b0, 64'h0, 3'b000);
        @(negedge clk);
        check("idx3_err_pulse", 64'(err_o), 64'd1);
        @(negedge clk);
        check("idx3_err_clear", 64'(err_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
